// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache fill controller.
package icache_pkg;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_REQ,
        FILL_RESP,
        FILL_WR,
        FILL_DONE
    } fill_state_t;

    localparam int unsigned DEF_ADDR_WID  = 64;
    localparam int unsigned DEF_INSTR_WID = 32;
    localparam int unsigned DEF_LENGTH    = 100;

    // Byte stride between consecutive words.
    function automatic int unsigned bytes_per_word(input int unsigned instr_wid);
        return instr_wid / 8;
    endfunction

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEF_INSTR_WID);

    // Width needed to hold a word count in 0..length inclusive.
    function automatic int unsigned cnt_width(input int unsigned length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache fill engine: reads words from the memory bus one at a time and writes them into
// the cache starting at cache address 0, sharing the cache address port with the fetch stage.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WID  = DEF_ADDR_WID,
    parameter int unsigned INSTR_WID = DEF_INSTR_WID,
    parameter int unsigned LENGTH    = DEF_LENGTH,
    localparam int unsigned CNT_WID  = cnt_width(LENGTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDR_WID-1:0]  base_addr_i,
    input  logic [CNT_WID-1:0]   num_words_i,
    output logic                 mem_req_o,
    output logic [ADDR_WID-1:0]  mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [INSTR_WID-1:0] mem_rdata_i,
    input  logic [ADDR_WID-1:0]  fetch_addr_i,
    output logic [ADDR_WID-1:0]  cache_addr_o,
    output logic                 wr_instr_en_o,
    output logic [INSTR_WID-1:0] wr_instr_o,
    output logic                 fetch_stall_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [ADDR_WID-1:0] ADDR_STEP = ADDR_WID'(bytes_per_word(INSTR_WID));
    localparam logic [CNT_WID-1:0]  CNT_LIMIT = CNT_WID'(LENGTH);
    localparam logic [CNT_WID-1:0]  CNT_ONE   = CNT_WID'(1);

    fill_state_t          state_q, state_d;
    logic [CNT_WID-1:0]   count_q;
    logic [CNT_WID-1:0]   idx_q;
    logic [ADDR_WID-1:0]  mem_addr_q;
    logic [ADDR_WID-1:0]  wr_addr_q;
    logic [INSTR_WID-1:0] data_q;
    logic                 err_q;
    logic                 busy;

    // State register, word counter, address counters, read-data capture and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FILL_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            mem_addr_q <= '0;
            wr_addr_q  <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                FILL_IDLE: begin
                    if (start_i) begin
                        count_q    <= num_words_i;
                        idx_q      <= '0;
                        mem_addr_q <= base_addr_i;
                        wr_addr_q  <= '0;
                        err_q      <= (num_words_i > CNT_LIMIT);
                    end
                end
                FILL_RESP: begin
                    if (mem_rvalid_i) begin
                        data_q <= mem_rdata_i;
                    end
                end
                FILL_WR: begin
                    // Memory and cache addresses advance together; adds wrap at ADDR_WID.
                    idx_q      <= idx_q + CNT_ONE;
                    mem_addr_q <= mem_addr_q + ADDR_STEP;
                    wr_addr_q  <= wr_addr_q + ADDR_STEP;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL_IDLE: begin
                if (start_i) begin
                    // Empty or oversized requests finish without touching memory.
                    if ((num_words_i == '0) || (num_words_i > CNT_LIMIT)) begin
                        state_d = FILL_DONE;
                    end else begin
                        state_d = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                if (mem_gnt_i) begin
                    state_d = FILL_RESP;
                end
            end
            FILL_RESP: begin
                // Only rvalid seen after the grant cycle counts.
                if (mem_rvalid_i) begin
                    state_d = FILL_WR;
                end
            end
            FILL_WR: begin
                state_d = ((idx_q + CNT_ONE) == count_q) ? FILL_DONE : FILL_REQ;
            end
            FILL_DONE: begin
                state_d = FILL_IDLE;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    // Output decode and cache address mux.
    always_comb begin
        mem_req_o     = 1'b0;
        wr_instr_en_o = 1'b0;
        done_o        = 1'b0;
        cache_addr_o  = fetch_addr_i;
        busy          = (state_q != FILL_IDLE);
        unique case (state_q)
            FILL_REQ: begin
                mem_req_o = 1'b1;
            end
            FILL_WR: begin
                wr_instr_en_o = 1'b1;
                cache_addr_o  = wr_addr_q;
            end
            FILL_DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr_o    = mem_addr_q;
    assign wr_instr_o    = data_q;
    assign err_o         = err_q;
    assign busy_o        = busy;
    assign fetch_stall_o = busy;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: table of fill requests plus hand-written reset and
// start-while-busy sequences; a memory responder feeds a write scoreboard.
`timescale 1ns/1ps
module tb_icache_fill_ctrl;
    import icache_pkg::*;

    localparam int unsigned AW  = 64;
    localparam int unsigned IW  = 32;
    localparam int unsigned LEN = 100;
    localparam int unsigned CW  = $clog2(LEN + 1);

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_words;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [IW-1:0] mem_rdata;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] cache_addr;
    logic          wr_en;
    logic [IW-1:0] wr_instr;
    logic          fetch_stall;
    logic          busy;
    logic          done;
    logic          err;

    icache_fill_ctrl #(
        .ADDR_WID  (AW),
        .INSTR_WID (IW),
        .LENGTH    (LEN)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .num_words_i   (num_words),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .fetch_addr_i  (fetch_addr),
        .cache_addr_o  (cache_addr),
        .wr_instr_en_o (wr_en),
        .wr_instr_o    (wr_instr),
        .fetch_stall_o (fetch_stall),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
    } wr_exp_t;

    typedef struct {
        logic [AW-1:0] base;
        int            n;
        int            g;
        int            r;
        bit            glitch;
        bit            exp_err;
    } vec_t;

    int checks;
    int errors;

    // Scoreboard and monitor state.
    wr_exp_t       sb[$];
    int            wr_cyc[$];
    int            cyc;
    int            start_cyc;
    int            done_cyc;
    int            done_cnt;
    int            wr_cnt;
    int            req_cnt;
    bit            mon_en;

    // Memory responder knobs and state.
    logic [AW-1:0] cur_base;
    int            k;
    int            gnt_dly;
    int            rv_dly;
    bit            glitch;
    int            g_cnt;
    int            rv_cnt;
    bit            rsp_pending;

    function automatic logic [IW-1:0] data_of(input logic [AW-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor and memory responder: sample on the falling edge, drive bus responses there too.
    initial begin
        wr_exp_t e;
        logic [AW-1:0] a;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        cyc         = 0;
        rsp_pending = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (start && !busy) start_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (mem_req) begin
                    req_cnt++;
                    check("mem_addr", mem_addr, cur_base + AW'(4 * k));
                end
                check("stall_eq_busy", fetch_stall, busy);
                if (wr_en) begin
                    wr_cnt++;
                    wr_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got write at 0x%0h, expected none",
                                 cache_addr);
                    end else begin
                        e = sb.pop_front();
                        check("wr_cache_addr", cache_addr, e.addr);
                        check("wr_data", AW'(wr_instr), AW'(e.data));
                    end
                end else begin
                    check("cache_mux", cache_addr, fetch_addr);
                end
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rsp_pending) begin
                if (rv_cnt == 0) begin
                    a          = cur_base + AW'(4 * k);
                    mem_rvalid = 1'b1;
                    mem_rdata  = data_of(a);
                    sb.push_back('{addr: AW'(4 * k), data: data_of(a)});
                    k++;
                    rsp_pending = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (mem_req && !rst) begin
                if (g_cnt == 0) begin
                    mem_gnt     = 1'b1;
                    rsp_pending = 1'b1;
                    rv_cnt      = rv_dly;
                    g_cnt       = gnt_dly;
                    // Spurious rvalid alongside the grant must be ignored.
                    if (glitch) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = 32'hBAD0_BAD0;
                    end
                end else begin
                    g_cnt--;
                end
            end
        end
    end

    task automatic prep(input logic [AW-1:0] b, input int g, input int r, input bit gl);
        cur_base    = b;
        k           = 0;
        gnt_dly     = g;
        rv_dly      = r;
        glitch      = gl;
        g_cnt       = g;
        rsp_pending = 1'b0;
        done_cnt    = 0;
        wr_cnt      = 0;
        req_cnt     = 0;
        start_cyc   = -1;
        done_cyc    = -1;
        sb.delete();
        wr_cyc.delete();
    endtask

    task automatic run_fill(input vec_t v);
        int words;
        int lat;
        int per;
        prep(v.base, v.g, v.r, v.glitch);
        words = (v.n == 0 || v.n > int'(LEN)) ? 0 : v.n;
        per   = 3 + v.g + v.r;
        lat   = 1 + words * per;
        tick();
        start     = 1'b1;
        base_addr = v.base;
        num_words = CW'(v.n);
        tick();
        start = 1'b0;
        for (int t = 0; t < 3000 && done_cnt == 0; t++) tick();
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o, expected done after %0d cycles", lat);
        end else begin
            check("done_latency", AW'(done_cyc - start_cyc), AW'(lat));
        end
        tick();
        tick();
        check("done_pulses", AW'(done_cnt), AW'(1));
        check("write_count", AW'(wr_cnt), AW'(words));
        check("req_cycles", AW'(req_cnt), AW'(words * (1 + v.g)));
        check("err", AW'(err), AW'(v.exp_err));
        check("busy_after", AW'(busy), '0);
        check("sb_empty", AW'(sb.size()), '0);
        for (int j = 0; j < wr_cyc.size(); j++) begin
            check("write_cycle", AW'(wr_cyc[j] - start_cyc), AW'((j + 1) * per));
        end
    endtask

    vec_t vecs[9];

    initial begin
        checks     = 0;
        errors     = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        num_words  = '0;
        fetch_addr = 64'h0000_0000_0000_0100;
        prep('0, 0, 0, 1'b0);

        vecs[0] = '{base: 64'h1000, n: 3, g: 0, r: 0, glitch: 1'b0, exp_err: 1'b0};
        vecs[1] = '{base: 64'h2000, n: 0, g: 0, r: 0, glitch: 1'b0, exp_err: 1'b0};
        vecs[2] = '{base: 64'h3000, n: 101, g: 0, r: 0, glitch: 1'b0, exp_err: 1'b1};
        vecs[3] = '{base: 64'h4000, n: 1, g: 0, r: 0, glitch: 1'b0, exp_err: 1'b0};
        vecs[4] = '{base: 64'h5000, n: 2, g: 4, r: 3, glitch: 1'b1, exp_err: 1'b0};
        vecs[5] = '{base: 64'hFFFF_FFFF_FFFF_FFF8, n: 4, g: 1, r: 0, glitch: 1'b0, exp_err: 1'b0};
        vecs[6] = '{base: 64'h1_0000, n: 100, g: 0, r: 0, glitch: 1'b0, exp_err: 1'b0};
        vecs[7] = '{base: 64'h20, n: 127, g: 0, r: 0, glitch: 1'b0, exp_err: 1'b1};
        vecs[8] = '{base: 64'h40, n: 2, g: 0, r: 2, glitch: 1'b1, exp_err: 1'b0};

        // Reset state.
        tick();
        tick();
        tick();
        check("rst_mem_req", AW'(mem_req), '0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_wr_en", AW'(wr_en), '0);
        check("rst_busy", AW'(busy), '0);
        check("rst_stall", AW'(fetch_stall), '0);
        check("rst_done", AW'(done), '0);
        check("rst_err", AW'(err), '0);
        check("rst_cache_addr", cache_addr, 64'h100);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_fill(vecs[i]);
        end

        // Reset during RESP of word 2 of 5.
        prep(64'h9000, 0, 0, 1'b0);
        tick();
        start     = 1'b1;
        base_addr = 64'h9000;
        num_words = CW'(5);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst        = 1'b1;
        fetch_addr = '0;
        tick();
        check("mrst_mem_req", AW'(mem_req), '0);
        check("mrst_mem_addr", mem_addr, '0);
        check("mrst_wr_en", AW'(wr_en), '0);
        check("mrst_wr_instr", AW'(wr_instr), '0);
        check("mrst_busy", AW'(busy), '0);
        check("mrst_stall", AW'(fetch_stall), '0);
        check("mrst_done", AW'(done), '0);
        check("mrst_err", AW'(err), '0);
        check("mrst_cache_addr", cache_addr, '0);
        rst         = 1'b0;
        rsp_pending = 1'b0;
        sb.delete();
        fetch_addr = 64'h8;
        #1;
        check("mrst_fetch_pass", cache_addr, 64'h8);
        check("mrst_fetch_stall", AW'(fetch_stall), '0);
        for (int i = 0; i < 6; i++) tick();
        check("mrst_no_done", AW'(done_cnt), '0);
        check("mrst_writes", AW'(wr_cnt), AW'(1));

        // Start pulses while busy are ignored; fetch address wanders during the fill.
        prep(64'h7000, 1, 1, 1'b0);
        tick();
        start     = 1'b1;
        base_addr = 64'h7000;
        num_words = CW'(4);
        for (int i = 1; i <= 21; i++) begin
            tick();
            start      = (i % 2 == 1) && (i != 21);
            base_addr  = {$urandom, $urandom};
            num_words  = CW'(1);
            fetch_addr = {$urandom, $urandom};
            check("busy_stall", AW'(fetch_stall), AW'(1));
        end
        tick();
        start = 1'b0;
        check("busy_end_stall", AW'(fetch_stall), '0);
        check("busy_done_once", AW'(done_cnt), AW'(1));
        check("busy_writes", AW'(wr_cnt), AW'(4));
        check("busy_latency", AW'(done_cyc - start_cyc), AW'(21));
        tick();
        tick();
        check("busy_no_restart", AW'(busy), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
